// File: rtl/palette_lut_if.sv
// -----------------------------------------------------------------------------
// palette_lut_if
// Bundles the pixel stream, the palette write port and the status flags of
// palette_lut into one interface.
//
// Parameters:
//   IDX_W    pixel index width (palette depth is 2**IDX_W)
//   COLOR_W  colour word width
//
// Signals (direction seen from the slave, i.e. the palette):
//   pix_valid  in   pixel index present this cycle
//   pix_index  in   palette index
//   pix_blank  in   blanking, forces output colour to 0
//   rgb_valid  out  pix_valid delayed by two cycles
//   rgb        out  looked-up colour
//   wr_en      in   palette write request
//   wr_addr    in   entry to write
//   wr_data    in   new entry value
//   wr_ready   out  write accepted when wr_en & wr_ready
//   init_busy  out  default-palette load in progress
//
// Modports: master (pixel source / host side), slave (palette_lut).
// -----------------------------------------------------------------------------
interface palette_lut_if #(
   parameter int IDX_W   = 8,
   parameter int COLOR_W = 8
);
   logic               pix_valid;
   logic [IDX_W-1:0]   pix_index;
   logic               pix_blank;
   logic               rgb_valid;
   logic [COLOR_W-1:0] rgb;
   logic               wr_en;
   logic [IDX_W-1:0]   wr_addr;
   logic [COLOR_W-1:0] wr_data;
   logic               wr_ready;
   logic               init_busy;

   modport master (
      output pix_valid, pix_index, pix_blank, wr_en, wr_addr, wr_data,
      input  rgb_valid, rgb, wr_ready, init_busy
   );

   modport slave (
      input  pix_valid, pix_index, pix_blank, wr_en, wr_addr, wr_data,
      output rgb_valid, rgb, wr_ready, init_busy
   );
endinterface

// File: rtl/palette_lut.sv
// -----------------------------------------------------------------------------
// palette_lut
// Run-time writable colour palette for the VGA pixel path. A pixel index is
// converted into a colour word through a two-stage pipeline:
//   S1 registers valid/index/blank, S2 reads the palette at the S1 index and
//   registers the colour into rgb (and valid into rgb_valid).
// The host can rewrite palette entries at any time once wr_ready is high; a
// write to the entry being read in the same cycle is forwarded (write-first).
//
// Optional feature, macro PALETTE_INIT_EN:
//   defined   -> after reset an INIT state sweeps all DEPTH entries, loading
//                entry i with i resized to COLOR_W bits, then enters RUN.
//   undefined -> no INIT state; the block is ready one cycle after reset
//                release and palette contents are undefined until written.
//
// Ports:
//   clk    in  pixel clock, all state on the rising edge
//   rst_n  in  asynchronous active-low reset (palette RAM is not cleared)
//   bus    palette_lut_if.slave (pixel stream, write port, status flags)
// -----------------------------------------------------------------------------
module palette_lut #(
   parameter int IDX_W   = 8,
   parameter int COLOR_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   palette_lut_if.slave  bus
);

   localparam int DEPTH = 2 ** IDX_W;

`ifdef PALETTE_INIT_EN
   localparam logic INIT_BUSY_RST = 1'b1;
`else
   localparam logic INIT_BUSY_RST = 1'b0;
`endif

   // palette storage
   logic [COLOR_W-1:0] mem_q [DEPTH];

   // single RAM write port, shared by the init sweep and host writes
   logic               mem_we_s;
   logic [IDX_W-1:0]   mem_waddr_s;
   logic [COLOR_W-1:0] mem_wdata_s;

   // pixel pipeline
   logic               s1_valid_q, s1_valid_d;
   logic               s1_blank_q, s1_blank_d;
   logic [IDX_W-1:0]   s1_index_q, s1_index_d;
   logic               rgb_valid_q, rgb_valid_d;
   logic [COLOR_W-1:0] rgb_q, rgb_d;
   logic [COLOR_W-1:0] rd_data_s;
   logic               pix_run_s;

   // status flags, registered so they change on the same edge as the state
   logic               wr_ready_q, wr_ready_d;
   logic               init_busy_q, init_busy_d;

`ifdef PALETTE_INIT_EN
   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [IDX_W-1:0] INIT_LAST = {IDX_W{1'b1}};

   state_e           state_q, state_d;
   logic [IDX_W-1:0] init_addr_q, init_addr_d;

   // Default palette entry: index truncated or zero-extended to colour width.
   function automatic logic [COLOR_W-1:0] init_value(input logic [IDX_W-1:0] idx);
      return COLOR_W'(idx);
   endfunction

   // FSM state and init sweep counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         init_addr_q <= {IDX_W{1'b0}};
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
      end
   end

   // FSM next state, sweep counter and next values of the status flags
   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      case (state_q)
         ST_INIT: begin
            if (init_addr_q == INIT_LAST) begin
               state_d     = ST_RUN;
               init_addr_d = {IDX_W{1'b0}};
            end else begin
               init_addr_d = init_addr_q + {{(IDX_W-1){1'b0}}, 1'b1};
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d     = ST_INIT;
            init_addr_d = {IDX_W{1'b0}};
         end
      endcase
      // flags follow the state being entered so wr_ready rises on the edge
      // that performs the last init write
      wr_ready_d  = (state_d == ST_RUN);
      init_busy_d = (state_d == ST_INIT);
   end

   // RAM write port: init sweep owns it during INIT, host afterwards
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = bus.wr_addr;
      mem_wdata_s = bus.wr_data;
      if (state_q == ST_INIT) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = init_addr_q;
         mem_wdata_s = init_value(init_addr_q);
      end else begin
         mem_we_s    = bus.wr_en & wr_ready_q;
         mem_waddr_s = bus.wr_addr;
         mem_wdata_s = bus.wr_data;
      end
   end

   assign pix_run_s = (state_q == ST_RUN);
`else
   // status flags without an init phase: ready from the first edge
   always_comb begin
      wr_ready_d  = 1'b1;
      init_busy_d = 1'b0;
   end

   // RAM write port: host writes only
   always_comb begin
      mem_we_s    = bus.wr_en & wr_ready_q;
      mem_waddr_s = bus.wr_addr;
      mem_wdata_s = bus.wr_data;
   end

   assign pix_run_s = 1'b1;
`endif

   // palette RAM; intentionally has no reset so contents survive rst_n
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[mem_waddr_s] <= mem_wdata_s;
      end
   end

   // pipeline next values: S1 capture, S2 read with write-first forwarding
   always_comb begin
      s1_valid_d  = bus.pix_valid;
      s1_blank_d  = bus.pix_blank;
      s1_index_d  = bus.pix_index;
      rgb_valid_d = s1_valid_q;
      rd_data_s   = mem_q[s1_index_q];
      rgb_d       = {COLOR_W{1'b0}};
      // wr_ready_q is only high in RUN, so no forwarding during INIT
      if (bus.wr_en && wr_ready_q && (bus.wr_addr == s1_index_q)) begin
         rd_data_s = bus.wr_data;
      end else begin
         rd_data_s = mem_q[s1_index_q];
      end
      if (s1_valid_q && !s1_blank_q && pix_run_s) begin
         rgb_d = rd_data_s;
      end else begin
         rgb_d = {COLOR_W{1'b0}};
      end
   end

   // pipeline and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_blank_q  <= 1'b0;
         s1_index_q  <= {IDX_W{1'b0}};
         rgb_valid_q <= 1'b0;
         rgb_q       <= {COLOR_W{1'b0}};
         wr_ready_q  <= 1'b0;
         init_busy_q <= INIT_BUSY_RST;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_blank_q  <= s1_blank_d;
         s1_index_q  <= s1_index_d;
         rgb_valid_q <= rgb_valid_d;
         rgb_q       <= rgb_d;
         wr_ready_q  <= wr_ready_d;
         init_busy_q <= init_busy_d;
      end
   end

   assign bus.rgb       = rgb_q;
   assign bus.rgb_valid = rgb_valid_q;
   assign bus.wr_ready  = wr_ready_q;
   assign bus.init_busy = init_busy_q;

endmodule
